pll_lock_supervisor: RTL and testbench

//  Runs on the free-running 50 MHz board reference clock, beside the fabric PLL that generates the 60 MHz pixel clock.

---
 rtl/pll_lock_supervisor.sv | 183 ++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Supervises a fabric PLL: holds it in reset, waits for a stable lock, then releases
// the downstream reset domains one at a time. Recycles the PLL on lock loss or lock timeout.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned NUM_RST        = 3,
  parameter int unsigned STAGGER        = 64,
  parameter int unsigned CNT_W          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               clear_status,
  output logic               pll_rst,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic               lock_lost,
  output logic [CNT_W-1:0]   retry_cnt,
  output logic [CNT_W-1:0]   loss_cnt
);

  localparam int unsigned REL_SPAN = NUM_RST * STAGGER;
  localparam int unsigned MAX_AB   = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int unsigned MAX_CD   = (REL_SPAN > PLL_RST_CYCLES) ? REL_SPAN : PLL_RST_CYCLES;
  localparam int unsigned CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] REL_LAST    = CW'((NUM_RST - 1) * STAGGER);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               locked_s;

  logic               pll_rst_q, pll_rst_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic               ready_q, ready_d;
  logic               lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic               retry_event;
  logic               loss_event;

  // Synchroniser for the asynchronous lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State, shared counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_cnt_q <= '0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      retry_cnt_q <= retry_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  // Next state, and output registers computed from the state being entered
  always_comb begin
    state_d     = state_q;
    retry_event = 1'b0;
    loss_event  = 1'b0;
    cnt_d       = cnt_q;
    pll_rst_d   = 1'b0;
    rst_out_d   = '1;
    ready_d     = 1'b0;
    lock_lost_d = lock_lost_q;
    retry_cnt_d = retry_cnt_q;
    loss_cnt_d  = loss_cnt_q;

    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_PLL_RST;
          retry_event = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          state_d    = S_PLL_RST;
          loss_event = 1'b1;
        end else if (cnt_q == REL_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d    = S_PLL_RST;
          loss_event = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    // Counter restarts on every state change and otherwise saturates
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end

    pll_rst_d = (state_d == S_PLL_RST);
    ready_d   = (state_d == S_RUN);

    // Bits only ever fall during release; anything else forces all high or all low
    for (int unsigned i = 0; i < NUM_RST; i++) begin
      if (state_d == S_RELEASE) begin
        rst_out_d[i] = rst_out_q[i] && (cnt_d != CW'(i * STAGGER));
      end else if (state_d == S_RUN) begin
        rst_out_d[i] = 1'b0;
      end else begin
        rst_out_d[i] = 1'b1;
      end
    end

    // Clear first so a same-cycle set or increment takes precedence
    if (clear_status) begin
      lock_lost_d = 1'b0;
      retry_cnt_d = '0;
      loss_cnt_d  = '0;
    end
    if (retry_event) begin
      retry_cnt_d = (retry_cnt_q == '1) ? retry_cnt_q : retry_cnt_q + CNT_W'(1);
    end
    if (loss_event) begin
      lock_lost_d = 1'b1;
      loss_cnt_d  = (loss_cnt_q == '1) ? loss_cnt_q : loss_cnt_q + CNT_W'(1);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_cnt_q;
  assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed scenarios plus random lock patterns,
// every cycle compared against a timeline model of the supervisor.
module tb_pll_lock_supervisor;

  localparam int unsigned SS  = 2;
  localparam int unsigned PRC = 4;
  localparam int unsigned TO  = 32;
  localparam int unsigned ST  = 8;
  localparam int unsigned NR  = 3;
  localparam int unsigned STG = 4;
  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_REL  = 3;
  localparam int PH_RUN  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          clear_status;
  logic          pll_rst;
  logic [NR-1:0] rst_out;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] retry_cnt;
  logic [CW-1:0] loss_cnt;

  int tests = 0;
  int fails = 0;

  // Model: current phase, cycles spent in it, lock history and status
  int m_phase;
  int m_t;
  bit m_pipe [SS];
  bit m_lost;
  int m_retry;
  int m_loss;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .SYNC_STAGES   (SS),
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (TO),
    .LOCK_STABLE   (ST),
    .NUM_RST       (NR),
    .STAGGER       (STG),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .clear_status(clear_status),
    .pll_rst     (pll_rst),
    .rst_out     (rst_out),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] exp_rst_out();
    logic [NR-1:0] v;
    for (int i = 0; i < int'(NR); i++) begin
      if (m_phase == PH_REL) v[i] = (m_t < i * int'(STG));
      else if (m_phase == PH_RUN) v[i] = 1'b0;
      else v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Advance the model by one clock edge
  task automatic m_edge(input bit r, input bit lk, input bit clr);
    bit ls;
    int nph;
    bit rev;
    bit lev;
    if (r) begin
      m_phase = PH_RST; m_t = 0; m_lost = 0; m_retry = 0; m_loss = 0;
      for (int k = 0; k < int'(SS); k++) m_pipe[k] = 1'b0;
      return;
    end
    ls  = m_pipe[SS-1];
    nph = m_phase;
    rev = 1'b0;
    lev = 1'b0;
    if (m_phase == PH_RST) begin
      if (m_t == int'(PRC) - 1) nph = PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      if (ls) nph = PH_STAB;
      else if (m_t == int'(TO) - 1) begin nph = PH_RST; rev = 1'b1; end
    end else if (m_phase == PH_STAB) begin
      if (!ls) nph = PH_WAIT;
      else if (m_t == int'(ST) - 1) nph = PH_REL;
    end else if (m_phase == PH_REL) begin
      if (!ls) begin nph = PH_RST; lev = 1'b1; end
      else if (m_t == int'((NR - 1) * STG)) nph = PH_RUN;
    end else begin
      if (!ls) begin nph = PH_RST; lev = 1'b1; end
    end
    if (nph != m_phase) m_t = 0;
    else m_t++;
    m_phase = nph;
    if (rev) m_retry = sat_inc(m_retry);
    else if (clr) m_retry = 0;
    if (lev) begin m_lost = 1'b1; m_loss = sat_inc(m_loss); end
    else if (clr) begin m_lost = 1'b0; m_loss = 0; end
    for (int k = int'(SS) - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = lk;
  endtask

  task automatic check_all();
    chk("pll_rst",   32'(pll_rst),   32'(m_phase == PH_RST));
    chk("rst_out",   32'(rst_out),   32'(exp_rst_out()));
    chk("ready",     32'(ready),     32'(m_phase == PH_RUN));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    chk("loss_cnt",  32'(loss_cnt),  32'(m_loss));
  endtask

  // One clock: drive, edge, update model, sample #1 later, return at negedge
  task automatic step(input bit lk, input bit clr);
    pll_locked   = lk;
    clear_status = clr;
    @(posedge clk);
    m_edge(rst, lk, clr);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit lk);
    rst = 1'b1;
    step(lk, 1'b0);
    step(lk, 1'b0);
    rst = 1'b0;
  endtask

  task automatic run_to(input int ph, input bit lk, input int bound, input string tag);
    int n = 0;
    while (m_phase != ph && n < bound) begin
      step(lk, 1'b0);
      n++;
    end
    tests++;
    assert (n < bound) else begin
      fails++;
      $error("FAIL %s: phase not reached after %0d cycles, required %0d", tag, n, ph);
    end
  endtask

  initial begin
    rst          = 1'b1;
    pll_locked   = 1'b1;
    clear_status = 1'b0;

    // 1: clean bring-up with lock held high
    do_reset(1'b1);
    chk("s1_reset_pll_rst", 32'(pll_rst), 32'd1);
    chk("s1_reset_rst_out", 32'(rst_out), 32'h7);
    run_to(PH_RUN, 1'b1, 100, "s1_run");
    step(1'b1, 1'b0);
    chk("s1_ready",   32'(ready),   32'd1);
    chk("s1_rst_out", 32'(rst_out), 32'd0);
    chk("s1_counts",  32'({retry_cnt, loss_cnt}), 32'd0);

    // 2: no lock for 100 cycles
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
    chk("s2_retry_cnt", 32'(retry_cnt), 32'd2);
    chk("s2_ready",     32'(ready),     32'd0);

    // Retry counter saturation
    for (int i = 0; i < 500; i++) step(1'b0, 1'b0);
    chk("s2_retry_sat", 32'(retry_cnt), 32'd15);
    step(1'b0, 1'b1);
    chk("s2_retry_clr", 32'(retry_cnt), 32'd0);

    // 3: short glitch while stabilising
    do_reset(1'b1);
    run_to(PH_STAB, 1'b1, 40, "s3_stable");
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_to(PH_RUN, 1'b1, 100, "s3_run");
    chk("s3_lock_lost", 32'(lock_lost), 32'd0);
    step(1'b1, 1'b0);
    chk("s3_ready", 32'(ready), 32'd1);

    // 4: lock loss in run, reassert on the third edge
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("s4_latency_rst_out", 32'(rst_out), 32'd0);
    step(1'b1, 1'b0);
    chk("s4_rst_out",   32'(rst_out),   32'h7);
    chk("s4_ready",     32'(ready),     32'd0);
    chk("s4_lock_lost", 32'(lock_lost), 32'd1);
    chk("s4_loss_cnt",  32'(loss_cnt),  32'd1);
    run_to(PH_RUN, 1'b1, 100, "s4_rerun");
    step(1'b1, 1'b1);
    chk("s4_clear", 32'({lock_lost, loss_cnt}), 32'd0);

    // 5: loss part-way through release
    do_reset(1'b1);
    run_to(PH_REL, 1'b1, 60, "s5_release");
    while (m_phase == PH_REL && m_t < int'(STG)) step(1'b1, 1'b0);
    chk("s5_partial", 32'(rst_out), 32'h4);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("s5_reassert", 32'(rst_out),  32'h7);
    chk("s5_loss_cnt", 32'(loss_cnt), 32'd1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
    chk("s5_held", 32'(rst_out), 32'h7);

    // 6: reset in run, then clear coinciding with a loss
    do_reset(1'b1);
    run_to(PH_RUN, 1'b1, 100, "s6_run");
    rst = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    chk("s6_rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("s6_rst_rst_out", 32'(rst_out), 32'h7);
    chk("s6_rst_ready",   32'(ready),   32'd0);
    run_to(PH_RUN, 1'b1, 100, "s6_rerun");
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("s6_coinc_lost", 32'(lock_lost), 32'd1);
    chk("s6_coinc_loss", 32'(loss_cnt),  32'd1);

    // Random lock patterns with sporadic status clears
    do_reset(1'b1);
    for (int s = 0; s < 60; s++) begin
      bit lvl;
      int len;
      lvl = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 60));
      for (int c = 0; c < len; c++) step(lvl, ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
